// File: rtl/reg_wb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_queue_pkg
// Description : Shared types and constants for the register writeback queue.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_wb_queue_pkg;

    localparam logic [4:0] REG_ZERO         = 5'd0;
    localparam int         WB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_bypass_match.sv
`default_nettype none
// ============================================================================
// Module      : wb_bypass_match
// Description : Combinational youngest-match search over the queued entries.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bypass_match
    import reg_wb_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic [4:0]                 addrs [DEPTH],
    input  logic [31:0]                datas [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [4:0]                 ra,
    output logic                       hit,
    output logic [31:0]                data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit   = 1'b0;
        data  = '0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (ra != REG_ZERO) && (addrs[w_idx] == ra)) begin
                hit  = 1'b1;
                data = datas[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_queue
// Description : Merges pipeline and mul/div writebacks into one register-file
//               write port through a FIFO, with read-port bypass lookup.
//               Optional trace print enabled by REG_WB_QUEUE_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_queue
    import reg_wb_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [31:0] md_pc,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        stall,
    output logic        RegWrite,
    output logic [4:0]  WA,
    output logic [31:0] WD,
    output logic [31:0] PC,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    output logic        FW1,
    output logic        FW2,
    output logic [31:0] FD1,
    output logic [31:0] FD2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_md_push;
    logic             w_wb_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_push_n;
    logic [PTR_W-1:0] w_wb_slot;
    wb_entry_t        w_head;
    logic [4:0]       w_addrs [DEPTH];
    logic [31:0]      w_datas [DEPTH];

    // Stall leaves room for two pushes even if nothing pops this cycle.
    assign stall     = (r_count > CNT_W'(DEPTH - 2));
    assign w_md_push = md_valid && (md_addr != REG_ZERO) && !stall;
    assign w_wb_push = wb_valid && (wb_addr != REG_ZERO) && !stall;
    assign w_pop     = (r_count != '0);
    assign w_push_n  = CNT_W'(w_md_push) + CNT_W'(w_wb_push);
    assign w_wb_slot = r_wr_ptr + PTR_W'(w_md_push);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + w_push_n - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: every reader is qualified by the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_md_push)
                r_mem[r_wr_ptr] <= '{pc: md_pc, addr: md_addr, data: md_data};
            if (w_wb_push)
                r_mem[w_wb_slot] <= '{pc: wb_pc, addr: wb_addr, data: wb_data};
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign RegWrite = w_pop;
    assign WA       = w_pop ? w_head.addr : '0;
    assign WD       = w_pop ? w_head.data : '0;
    assign PC       = w_pop ? w_head.pc   : '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_split
        assign w_addrs[g] = r_mem[g].addr;
        assign w_datas[g] = r_mem[g].data;
    end

    wb_bypass_match #(.DEPTH(DEPTH)) u_match1 (
        .addrs (w_addrs),
        .datas (w_datas),
        .head  (r_rd_ptr),
        .count (r_count),
        .ra    (RA1),
        .hit   (FW1),
        .data  (FD1)
    );

    wb_bypass_match #(.DEPTH(DEPTH)) u_match2 (
        .addrs (w_addrs),
        .datas (w_datas),
        .head  (r_rd_ptr),
        .count (r_count),
        .ra    (RA2),
        .hit   (FW2),
        .data  (FD2)
    );

`ifdef REG_WB_QUEUE_TRACE_EN
    always @(posedge clk) begin
        if (!reset && RegWrite)
            $display("@%h: $%d <= %h", PC, WA, WD);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_queue
// Description : Directed self-checking bench for reg_wb_queue (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, md_valid;
    logic [31:0] wb_pc, wb_data, md_pc, md_data;
    logic [4:0]  wb_addr, md_addr;
    logic        stall, RegWrite, FW1, FW2;
    logic [4:0]  WA, RA1, RA2;
    logic [31:0] WD, PC, FD1, FD2;

    int checks   = 0;
    int failures = 0;

    reg_wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_pc(md_pc), .md_addr(md_addr), .md_data(md_data),
        .stall(stall), .RegWrite(RegWrite), .WA(WA), .WD(WD), .PC(PC),
        .RA1(RA1), .RA2(RA2), .FW1(FW1), .FW2(FW2), .FD1(FD1), .FD2(FD2)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        failures++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive_md(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        md_valid = v; md_addr = a; md_data = d; md_pc = p;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        wb_valid = v; wb_addr = a; wb_data = d; wb_pc = p;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; RA1 = 5'd0; RA2 = 5'd0;
        drive_md(1'b0, 5'd0, 32'h0, 32'h0);
        drive_wb(1'b1, 5'd7, 32'hDEAD, 32'h10);

        // Reset state, with a request held during reset
        tick(); tick(); #1;
        checks++; if (RegWrite !== 1'b0) fail("rst_regwrite", RegWrite, 1'b0);
        checks++; if (WA !== 5'd0) fail("rst_wa", WA, 5'd0);
        checks++; if (WD !== 32'h0) fail("rst_wd", WD, 32'h0);
        checks++; if (PC !== 32'h0) fail("rst_pc", PC, 32'h0);
        checks++; if (stall !== 1'b0) fail("rst_stall", stall, 1'b0);
        RA1 = 5'd7; RA2 = 5'd7; #1;
        checks++; if (FW1 !== 1'b0) fail("rst_fw1", FW1, 1'b0);
        checks++; if (FD1 !== 32'h0) fail("rst_fd1", FD1, 32'h0);
        checks++; if (FW2 !== 1'b0) fail("rst_fw2", FW2, 1'b0);
        checks++; if (FD2 !== 32'h0) fail("rst_fd2", FD2, 32'h0);
        reset = 1'b0; drive_wb(1'b0, 5'd0, 32'h0, 32'h0);
        tick(); #1;
        checks++; if (RegWrite !== 1'b0) fail("rst_input_ignored", RegWrite, 1'b0);

        // Single write, no cut-through
        drive_wb(1'b1, 5'd8, 32'h1234, 32'h3000); RA1 = 5'd8; #1;
        checks++; if (RegWrite !== 1'b0) fail("single_no_cut", RegWrite, 1'b0);
        checks++; if (FW1 !== 1'b0) fail("single_no_bypass_input", FW1, 1'b0);
        tick(); drive_wb(1'b0, 5'd0, 32'h0, 32'h0); #1;
        checks++; if (RegWrite !== 1'b1) fail("single_regwrite", RegWrite, 1'b1);
        checks++; if (WA !== 5'd8) fail("single_wa", WA, 5'd8);
        checks++; if (WD !== 32'h0000_1234) fail("single_wd", WD, 32'h0000_1234);
        checks++; if (PC !== 32'h3000) fail("single_pc", PC, 32'h3000);
        tick(); #1;
        checks++; if (RegWrite !== 1'b0) fail("single_drained", RegWrite, 1'b0);

        // Simultaneous: md first, then wb; bypass on both ports
        drive_md(1'b1, 5'd5, 32'hA, 32'h100);
        drive_wb(1'b1, 5'd6, 32'hB, 32'h104);
        RA1 = 5'd5; #1;
        checks++; if (FW1 !== 1'b0) fail("simul_same_cycle_bypass", FW1, 1'b0);
        tick(); drive_md(1'b0, 5'd0, 32'h0, 32'h0); drive_wb(1'b0, 5'd0, 32'h0, 32'h0);
        RA1 = 5'd6; RA2 = 5'd5; #1;
        checks++; if (WA !== 5'd5) fail("simul_first_wa", WA, 5'd5);
        checks++; if (WD !== 32'hA) fail("simul_first_wd", WD, 32'hA);
        checks++; if (PC !== 32'h100) fail("simul_first_pc", PC, 32'h100);
        checks++; if (FW1 !== 1'b1) fail("simul_fw1", FW1, 1'b1);
        checks++; if (FD1 !== 32'hB) fail("simul_fd1", FD1, 32'hB);
        checks++; if (FW2 !== 1'b1) fail("simul_fw2", FW2, 1'b1);
        checks++; if (FD2 !== 32'hA) fail("simul_fd2", FD2, 32'hA);
        tick(); #1;
        checks++; if (RegWrite !== 1'b1) fail("simul_second_regwrite", RegWrite, 1'b1);
        checks++; if (WA !== 5'd6) fail("simul_second_wa", WA, 5'd6);
        checks++; if (WD !== 32'hB) fail("simul_second_wd", WD, 32'hB);
        checks++; if (FW2 !== 1'b0) fail("simul_fw2_popped", FW2, 1'b0);
        checks++; if (FD2 !== 32'h0) fail("simul_fd2_popped", FD2, 32'h0);
        tick(); #1;
        checks++; if (RegWrite !== 1'b0) fail("simul_drained", RegWrite, 1'b0);

        // Zero address is discarded
        drive_wb(1'b1, 5'd0, 32'hFF, 32'h200);
        tick(); drive_wb(1'b0, 5'd0, 32'h0, 32'h0); #1;
        checks++; if (RegWrite !== 1'b0) fail("zero_no_write", RegWrite, 1'b0);
        drive_md(1'b1, 5'd0, 32'hEE, 32'h204);
        drive_wb(1'b1, 5'd9, 32'h99, 32'h208);
        RA1 = 5'd0; #1;
        tick(); drive_md(1'b0, 5'd0, 32'h0, 32'h0); drive_wb(1'b0, 5'd0, 32'h0, 32'h0); #1;
        checks++; if (WA !== 5'd9) fail("zero_pair_wa", WA, 5'd9);
        checks++; if (WD !== 32'h99) fail("zero_pair_wd", WD, 32'h99);
        checks++; if (FW1 !== 1'b0) fail("zero_ra_no_hit", FW1, 1'b0);
        tick(); #1;
        checks++; if (RegWrite !== 1'b0) fail("zero_pair_drained", RegWrite, 1'b0);

        // Bypass youngest match
        drive_md(1'b1, 5'd3, 32'h1, 32'h300);
        drive_wb(1'b1, 5'd3, 32'h2, 32'h304);
        tick(); drive_md(1'b0, 5'd0, 32'h0, 32'h0); drive_wb(1'b0, 5'd0, 32'h0, 32'h0);
        RA1 = 5'd3; RA2 = 5'd4; #1;
        checks++; if (FW1 !== 1'b1) fail("bypass_fw1", FW1, 1'b1);
        checks++; if (FD1 !== 32'h2) fail("bypass_fd1_youngest", FD1, 32'h2);
        checks++; if (FW2 !== 1'b0) fail("bypass_miss_fw2", FW2, 1'b0);
        checks++; if (FD2 !== 32'h0) fail("bypass_miss_fd2", FD2, 32'h0);
        checks++; if (WD !== 32'h1) fail("bypass_head_wd", WD, 32'h1);
        tick(); #1;
        checks++; if (FD1 !== 32'h2) fail("bypass_after_pop_fd1", FD1, 32'h2);
        tick(); #1;
        checks++; if (FW1 !== 1'b0) fail("bypass_empty_fw1", FW1, 1'b0);
        RA1 = 5'd0; RA2 = 5'd0;

        // Stall and wrap: three pairs, third held while stalled
        drive_md(1'b1, 5'd10, 32'h100, 32'h400); drive_wb(1'b1, 5'd11, 32'h101, 32'h404); #1;
        checks++; if (stall !== 1'b0) fail("wrap_n0_stall", stall, 1'b0);
        tick();
        drive_md(1'b1, 5'd12, 32'h102, 32'h408); drive_wb(1'b1, 5'd13, 32'h103, 32'h40C); #1;
        checks++; if (stall !== 1'b0) fail("wrap_n1_stall", stall, 1'b0);
        checks++; if (WA !== 5'd10) fail("wrap_n1_wa", WA, 5'd10);
        tick();
        drive_md(1'b1, 5'd14, 32'h104, 32'h410); drive_wb(1'b1, 5'd15, 32'h105, 32'h414); #1;
        checks++; if (stall !== 1'b1) fail("wrap_n2_stall", stall, 1'b1);
        checks++; if (WA !== 5'd11) fail("wrap_n2_wa", WA, 5'd11);
        tick(); #1;
        checks++; if (stall !== 1'b0) fail("wrap_n3_stall", stall, 1'b0);
        checks++; if (WA !== 5'd12) fail("wrap_n3_wa", WA, 5'd12);
        tick(); drive_md(1'b0, 5'd0, 32'h0, 32'h0); drive_wb(1'b0, 5'd0, 32'h0, 32'h0); #1;
        checks++; if (stall !== 1'b1) fail("wrap_n4_stall", stall, 1'b1);
        checks++; if (WA !== 5'd13) fail("wrap_n4_wa", WA, 5'd13);
        tick(); #1;
        checks++; if (WA !== 5'd14) fail("wrap_n5_wa", WA, 5'd14);
        checks++; if (WD !== 32'h104) fail("wrap_n5_wd", WD, 32'h104);
        tick(); #1;
        checks++; if (WA !== 5'd15) fail("wrap_n6_wa", WA, 5'd15);
        checks++; if (PC !== 32'h414) fail("wrap_n6_pc", PC, 32'h414);
        tick(); #1;
        checks++; if (RegWrite !== 1'b0) fail("wrap_drained", RegWrite, 1'b0);

        // Reset mid-drain with three entries queued
        drive_md(1'b1, 5'd20, 32'h20, 32'h500); drive_wb(1'b1, 5'd21, 32'h21, 32'h504);
        tick();
        drive_md(1'b1, 5'd22, 32'h22, 32'h508); drive_wb(1'b1, 5'd23, 32'h23, 32'h50C);
        tick(); drive_md(1'b0, 5'd0, 32'h0, 32'h0); drive_wb(1'b1, 5'd24, 32'h24, 32'h510); #1;
        checks++; if (stall !== 1'b1) fail("rstmid_stall_before", stall, 1'b1);
        checks++; if (WA !== 5'd21) fail("rstmid_wa_before", WA, 5'd21);
        reset = 1'b1;
        tick(); reset = 1'b0; drive_wb(1'b0, 5'd0, 32'h0, 32'h0); RA1 = 5'd22; #1;
        checks++; if (RegWrite !== 1'b0) fail("rstmid_regwrite", RegWrite, 1'b0);
        checks++; if (stall !== 1'b0) fail("rstmid_stall", stall, 1'b0);
        checks++; if (FW1 !== 1'b0) fail("rstmid_fw1", FW1, 1'b0);
        tick(); #1;
        checks++; if (RegWrite !== 1'b0) fail("rstmid_no_stale1", RegWrite, 1'b0);
        tick(); #1;
        checks++; if (RegWrite !== 1'b0) fail("rstmid_no_stale2", RegWrite, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4, meaning the number of queued register writes (power of two, 2..16).
REQ-002 The block SHALL expose clk  input  1  the sole clock, with all state updated on the rising edge.
REQ-003 The block SHALL expose reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL expose the pipeline writeback source, all inputs:
- wb_valid  1  write request.
- wb_pc  32  instruction address.
- wb_addr  5  destination register.
- wb_data  32  result.
REQ-005 The block SHALL expose the multiply/divide writeback source, all inputs:
- md_valid  1  write request.
- md_pc  32  instruction address.
- md_addr  5  destination register.
- md_data  32  result.
REQ-006 The block SHALL expose stall  output  1  meaning the queue cannot accept two requests next cycle.
REQ-007 The block SHALL expose the register-file write port, all outputs:
- RegWrite  1  write strobe.
- WA  5  write address.
- WD  32  write data.
- PC  32  instruction address for the trace.
REQ-008 The block SHALL expose the bypass lookup ports:
- RA1, RA2  input  5  read addresses.
- FW1, FW2  output  1  hit flags.
- FD1, FD2  output  32  bypass data.

Function
REQ-009 The block SHALL hold a circular FIFO of DEPTH entries {pc, addr, data} with wrapping read/write pointers and a count of width $clog2(DEPTH)+1.
REQ-010 The block SHALL discard at enqueue any request whose address is 0, so that it occupies no entry and never reaches RegWrite.
REQ-011 When both sources are valid in the same cycle, the block SHALL enqueue the md entry first (older in program order), then the wb entry.
REQ-012 The block SHALL drive RegWrite=1 with WA/WD/PC taken from the head entry whenever count>0, combinationally from the head, with zero added latency.
REQ-013 The block SHALL pop the head on every cycle in which RegWrite=1, so that the register file consumes one entry per cycle.
REQ-014 When the queue is empty and a request arrives, the block SHALL present it on RegWrite no earlier than the next cycle; there SHALL be no cut-through.
REQ-015 A push and a pop in the same cycle SHALL leave count changed by (pushes - 1).
REQ-016 Pushes SHALL wrap the write pointer from DEPTH-1 to 0 without loss.
REQ-017 The block SHALL assert stall when count > DEPTH-2.
REQ-018 Requests presented while stall=1 SHALL be ignored; upstream holds them.
REQ-019 FWn SHALL be 1 when any valid queued entry has addr==RAn and RAn!=0.
REQ-020 FDn SHALL be the data of the youngest matching entry; FDn SHALL be 0 when FWn=0.
REQ-021 The bypass SHALL see only queued entries, not same-cycle inputs.

Reset
REQ-022 On reset the block SHALL clear pointers and count, and drive RegWrite=0, WA=0, WD=0, PC=0, stall=0, FW1=FW2=0, FD1=FD2=0.
REQ-023 Reset mid-operation SHALL drop all queued entries, and inputs in the reset cycle SHALL be ignored.

Configuration
REQ-024 With macro REG_WB_QUEUE_TRACE_EN defined, each cycle with RegWrite=1 SHALL print "@%h: $%d <= %h" using PC, WA, WD at the rising edge.
REQ-025 Without REG_WB_QUEUE_TRACE_EN, the block SHALL contain no $display and its behaviour SHALL otherwise be identical.

Structure
REQ-026 A shared package SHALL hold:
- typedef wb_entry_t {pc[31:0], addr[4:0], data[31:0]}.
- constants REG_ZERO=5'd0 and WB_DEPTH_DEFAULT=4.
REQ-027 One sub-module, wb_bypass_match, SHALL be used: a combinational youngest-match search instanced once per read port.

Verification
REQ-028 Single write: wb_valid with addr=8, data=0x1234, pc=0x3000 -> the next cycle shows RegWrite=1, WA=8, WD=0x00001234, PC=0x3000, then RegWrite=0.
REQ-029 Simultaneous requests: md(addr=5, data=0xA) and wb(addr=6, data=0xB) in one cycle -> WA=5 is written first, then WA=6 on the following cycle.
REQ-030 Zero address: wb_valid with addr=0 -> RegWrite is never asserted and count stays 0.
REQ-031 Bypass: queue holds addr=3 entries with data 0x1 (older) and 0x2 (younger); drive RA1=3 -> FW1=1 and FD1=0x2.
REQ-032 Stall and wrap: with DEPTH=4, both sources valid for 3 consecutive cycles -> stall asserts once count>2, no entry is lost, the full drain order matches program order, and the pointers wrap.
REQ-033 Reset mid-drain: with 3 entries queued, assert reset for 1 cycle -> RegWrite=0 and count=0 the cycle after, and no stale writes follow.
